// File: rtl/ofs_plat_reset_sequencer.sv
// ----------------------------------------------------------------------------
// OfsPlatResetSequencer (module ofs_plat_reset_sequencer)
//
// Purpose:
//    Releases a set of reset domains one at a time, in index order. All
//    domains first sit in reset for HOLD_CYCLES clocks. Each domain is then
//    released and the sequencer waits for that domain's ready acknowledge
//    before moving to the next one. Once the last domain acknowledges, the
//    block reports all_ready and idles until a hard or soft reset restarts
//    the whole sequence.
//
// Optional feature (macro OFS_PLAT_RESET_SEQ_TIMEOUT_EN):
//    When defined, a per-domain wait counter limits the acknowledge wait to
//    TIMEOUT_CYCLES clocks. A domain that never acknowledges is flagged in
//    timeout_mask / timeout_err (sticky) and the sequence moves on anyway.
//    When undefined, the sequencer waits forever and both flags read 0.
//
// Parameters:
//    NUM_DOMAINS    - number of sequenced reset domains (2..16)
//    HOLD_CYCLES    - minimum cycles every domain stays in reset (>= 1)
//    TIMEOUT_CYCLES - per-domain acknowledge wait limit (>= 2)
//
// Ports:
//    clk           in   sole clock, rising edge
//    reset         in   asynchronous active-high reset
//    reset_req     in   synchronous soft reset request (level)
//    domain_ready  in   per-domain "out of reset and ready" acknowledge
//    rst_n_out     out  per-domain active-low reset, registered
//    cur_domain    out  index of the domain currently being released
//    busy          out  sequence in progress
//    all_ready     out  every domain released and acknowledged
//    timeout_err   out  sticky: some domain acknowledge timed out
//    timeout_mask  out  sticky: which domains timed out
// ----------------------------------------------------------------------------
module ofs_plat_reset_sequencer #(
   parameter int NUM_DOMAINS    = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           reset_req,
   input  logic [NUM_DOMAINS-1:0]         domain_ready,
   output logic [NUM_DOMAINS-1:0]         rst_n_out,
   output logic [$clog2(NUM_DOMAINS)-1:0] cur_domain,
   output logic                           busy,
   output logic                           all_ready,
   output logic                           timeout_err,
   output logic [NUM_DOMAINS-1:0]         timeout_mask
);

   localparam int DW = $clog2(NUM_DOMAINS);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
   localparam logic [DW-1:0] LAST_DOMAIN = DW'(NUM_DOMAINS - 1);

   // Illegal parameter combinations are rejected at elaboration rather than
   // producing a sequencer with silently truncated counters.
   if (NUM_DOMAINS < 2 || NUM_DOMAINS > 16 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_paramCheck
      $error("ofs_plat_reset_sequencer: illegal parameter value");
   end

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_RELEASE  = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_RUN      = 2'd3
   } state_t;

   state_t                 r_state;
   logic [HW-1:0]          r_holdCnt;
   logic [DW-1:0]          r_curDomain;
   logic [NUM_DOMAINS-1:0] r_rstN;
   logic                   r_busy;
   logic                   r_allReady;

   logic                   w_curReady;
   logic                   w_timeoutHit;
   logic                   w_advance;

   // Only the acknowledge of the domain being released matters; the FSM
   // additionally qualifies it with the WAIT_ACK state, so every other bit
   // and every bit outside WAIT_ACK is ignored.
   assign w_curReady = domain_ready[r_curDomain];
   assign w_advance  = w_curReady | w_timeoutHit;

`ifdef OFS_PLAT_RESET_SEQ_TIMEOUT_EN

   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

   logic [WW-1:0]          r_waitCnt;
   logic                   r_timeoutErr;
   logic [NUM_DOMAINS-1:0] r_timeoutMask;

   // A timeout only fires on the last allowed waiting edge and only when the
   // real acknowledge is absent, so a late-but-in-time ack is never flagged.
   assign w_timeoutHit = (r_state == ST_WAIT_ACK) && !w_curReady && (r_waitCnt == WAIT_LAST);

   // Wait counter and sticky timeout flags. The counter restarts every time
   // a domain is released, so each domain gets its own full wait budget.
   // The flags survive the rest of the sequence and the RUN state and are
   // only cleared by a hard reset or a soft reset request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_waitCnt     <= '0;
         r_timeoutErr  <= 1'b0;
         r_timeoutMask <= '0;
      end else if (reset_req) begin
         r_waitCnt     <= '0;
         r_timeoutErr  <= 1'b0;
         r_timeoutMask <= '0;
      end else begin
         if (r_state == ST_RELEASE) begin
            r_waitCnt <= '0;
         end else if (r_state == ST_WAIT_ACK && !w_advance) begin
            r_waitCnt <= r_waitCnt + 1'b1;
         end
         if (w_timeoutHit) begin
            r_timeoutErr               <= 1'b1;
            r_timeoutMask[r_curDomain] <= 1'b1;
         end
      end
   end

   assign timeout_err  = r_timeoutErr;
   assign timeout_mask = r_timeoutMask;

`else

   // Without the timeout feature the sequencer waits on each domain forever.
   assign w_timeoutHit = 1'b0;
   assign timeout_err  = 1'b0;
   assign timeout_mask = '0;

`endif

   // Main sequencing FSM. A soft reset request takes priority over anything
   // the current state would do, including an ack or timeout on the same
   // edge, and throws every domain back into reset. Released domains are
   // only ever set, never cleared, until the next hard or soft reset, so a
   // domain cannot be bounced while the sequence continues. The hard reset
   // clears rst_n_out through the async clear, so outputs drop immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_HOLD;
         r_holdCnt   <= '0;
         r_curDomain <= '0;
         r_rstN      <= '0;
         r_busy      <= 1'b1;
         r_allReady  <= 1'b0;
      end else if (reset_req) begin
         r_state     <= ST_HOLD;
         r_holdCnt   <= '0;
         r_curDomain <= '0;
         r_rstN      <= '0;
         r_busy      <= 1'b1;
         r_allReady  <= 1'b0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_holdCnt == HOLD_LAST) begin
                  r_holdCnt   <= '0;
                  r_curDomain <= '0;
                  r_state     <= ST_RELEASE;
               end else begin
                  r_holdCnt <= r_holdCnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               r_rstN[r_curDomain] <= 1'b1;
               r_state             <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (w_advance) begin
                  if (r_curDomain == LAST_DOMAIN) begin
                     r_state    <= ST_RUN;
                     r_busy     <= 1'b0;
                     r_allReady <= 1'b1;
                  end else begin
                     r_curDomain <= r_curDomain + 1'b1;
                     r_state     <= ST_RELEASE;
                  end
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_HOLD;
            end
         endcase
      end
   end

   assign rst_n_out  = r_rstN;
   assign cur_domain = r_curDomain;
   assign busy       = r_busy;
   assign all_ready  = r_allReady;

endmodule

// File: tb/tb_ofs_plat_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ofs_plat_reset_sequencer
//
// Self-checking bench for ofs_plat_reset_sequencer (4 domains, 4 hold
// cycles). The acknowledge timeout is 8 cycles when
// OFS_PLAT_RESET_SEQ_TIMEOUT_EN is defined, 1024 otherwise.
//
// The reference model is a release timeline: it remembers at which edge the
// next domain is due to be released, which domain is awaiting an ack and
// since which edge, and derives every output from that.
// ----------------------------------------------------------------------------
module tb_ofs_plat_reset_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 4;
`ifdef OFS_PLAT_RESET_SEQ_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
   localparam bit TO_EN      = 1'b1;
`else
   localparam int TB_TIMEOUT = 1024;
   localparam bit TO_EN      = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         reset_req;
   logic [N-1:0] domain_ready;
   logic [N-1:0] rst_n_out;
   logic [1:0]   cur_domain;
   logic         busy;
   logic         all_ready;
   logic         timeout_err;
   logic [N-1:0] timeout_mask;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int           mEdge;
   int           mRelAt;
   int           mWaitFrom;
   bit           mWaiting;
   bit           mRunning;
   logic [1:0]   mCur;
   logic [N-1:0] mRel;
   logic [N-1:0] mMask;

   typedef struct {
      logic         req;
      logic [N-1:0] ready;
      logic [N-1:0] expRst;
      logic [1:0]   expCur;
      logic         expBusy;
      logic         expAllReady;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   ofs_plat_reset_sequencer #(
      .NUM_DOMAINS   (N),
      .HOLD_CYCLES   (HOLD),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reset_req   (reset_req),
      .domain_ready(domain_ready),
      .rst_n_out   (rst_n_out),
      .cur_domain  (cur_domain),
      .busy        (busy),
      .all_ready   (all_ready),
      .timeout_err (timeout_err),
      .timeout_mask(timeout_mask)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start a new release timeline counted from the current edge
   task automatic modelRestart();
      mRelAt   = mEdge + HOLD + 1;
      mCur     = '0;
      mWaiting = 1'b0;
      mRunning = 1'b0;
      mRel     = '0;
      mMask    = '0;
   endtask

   task automatic modelReset();
      mEdge = 0;
      modelRestart();
   endtask

   // Advance the model by one clock edge using the inputs the DUT sampled
   task automatic modelEdge();
      bit hit;
      hit = 1'b0;
      mEdge++;
      if (reset_req) begin
         modelRestart();
      end else if (!mWaiting && !mRunning && mEdge == mRelAt) begin
         mRel[mCur] = 1'b1;
         mWaiting   = 1'b1;
         mWaitFrom  = mEdge;
      end else if (mWaiting) begin
         if (domain_ready[mCur]) begin
            hit = 1'b1;
         end else if (TO_EN && (mEdge - mWaitFrom == TB_TIMEOUT)) begin
            hit         = 1'b1;
            mMask[mCur] = 1'b1;
         end
         if (hit) begin
            mWaiting = 1'b0;
            if (mCur == 2'(N - 1)) begin
               mRunning = 1'b1;
            end else begin
               mCur   = mCur + 1'b1;
               mRelAt = mEdge + 1;
            end
         end
      end
   endtask

   // Drive inputs (called just after a falling edge), let one rising edge
   // happen, step the model, and return on the next falling edge
   task automatic applyStimulus(input logic req, input logic [N-1:0] ready);
      reset_req    = req;
      domain_ready = ready;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   // Compare every output against the reference model
   task automatic checkOutput(input string name);
      checks++;
      if (rst_n_out !== mRel || cur_domain !== mCur || busy !== !mRunning ||
          all_ready !== mRunning || timeout_err !== (|mMask) || timeout_mask !== mMask) begin
         errors++;
         $display("[TB] FAIL %s @%0t: got rst=%b cur=%0d busy=%b allrdy=%b err=%b mask=%b, expected rst=%b cur=%0d busy=%b allrdy=%b err=%b mask=%b",
                  name, $time, rst_n_out, cur_domain, busy, all_ready, timeout_err, timeout_mask,
                  mRel, mCur, !mRunning, mRunning, |mMask, mMask);
      end
   endtask

   // Compare one value against a fixed expectation
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Hard reset: assert, check the reset state while it is held, release on
   // a falling edge so the next rising edge is edge 1 of a new sequence
   task automatic doReset();
      reset        = 1'b1;
      reset_req    = 1'b0;
      domain_ready = '0;
      #1;
      modelReset();
      checkOutput("reset_state");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      logic [N-1:0] rnd;

      // Edge-by-edge expectation of a clean sequence with every ack tied
      // high, then a one-cycle soft reset in RUN while ready toggles
      for (int i = 0; i < 4; i++) vecs[i] = '{1'b0, 4'hF, 4'b0000, 2'd0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 4'hF, 4'b0001, 2'd0, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 4'hF, 4'b0001, 2'd1, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 4'hF, 4'b0011, 2'd1, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 4'hF, 4'b0011, 2'd2, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 4'hF, 4'b0111, 2'd2, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'hF, 4'b0111, 2'd3, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 4'hF, 4'b1111, 2'd3, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 4'hF, 4'b1111, 2'd3, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 4'hF, 4'b1111, 2'd3, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 4'h5, 4'b0000, 2'd0, 1'b1, 1'b0};
      for (int i = 14; i < 18; i++) vecs[i] = '{1'b0, 4'hA, 4'b0000, 2'd0, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 4'hA, 4'b0001, 2'd0, 1'b1, 1'b0};

      reset        = 1'b1;
      reset_req    = 1'b0;
      domain_ready = '0;
      doReset();

      $display("[TB] table-driven sequence");
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].req, vecs[i].ready);
         checkVal($sformatf("vec%0d", i + 1),
                  {19'd0, rst_n_out, cur_domain, busy, all_ready, timeout_err, timeout_mask},
                  {19'd0, vecs[i].expRst, vecs[i].expCur, vecs[i].expBusy, vecs[i].expAllReady, 1'b0, 4'b0000});
         checkOutput("vec_model");
      end

      $display("[TB] soft reset held after hard reset");
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 4'hF);
      checkVal("req_held_rst", {28'd0, rst_n_out}, 32'd0);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b0, 4'hF);
         checkOutput("req_release_model");
         if (rst_n_out[0] === 1'b1) begin
            n = i;
            break;
         end
      end
      checkVal("req_release_latency", n, 5);

      $display("[TB] domain 1 acknowledge stalled");
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 4'b1101);
         checkOutput("stall_model");
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 4'b1101);
         checkOutput("stall_model");
      end
`ifndef OFS_PLAT_RESET_SEQ_TIMEOUT_EN
      checkVal("stall_cur", {30'd0, cur_domain}, 32'd1);
      checkVal("stall_rst", {28'd0, rst_n_out}, 32'b0011);
`endif
      applyStimulus(1'b0, 4'hF);
      checkOutput("stall_ack_model");
      applyStimulus(1'b0, 4'hF);
      checkOutput("stall_rel_model");
`ifndef OFS_PLAT_RESET_SEQ_TIMEOUT_EN
      checkVal("stall_rel2", {28'd0, rst_n_out}, 32'b0111);
      checkVal("stall_noerr", {31'd0, timeout_err}, 32'd0);
`endif

      $display("[TB] domain 0 never acknowledges");
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0);
      checkVal("dead_rel0", {28'd0, rst_n_out}, 32'b0001);
`ifdef OFS_PLAT_RESET_SEQ_TIMEOUT_EN
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'h0);
      checkVal("dead_pre_timeout", {27'd0, timeout_err, timeout_mask}, 32'd0);
      applyStimulus(1'b0, 4'h0);
      checkVal("dead_timeout", {25'd0, timeout_err, timeout_mask, cur_domain}, {25'd0, 1'b1, 4'b0001, 2'd1});
      checkOutput("dead_timeout_model");
      applyStimulus(1'b1, 4'hF);
      checkVal("req_clears_mask", {23'd0, timeout_err, timeout_mask, rst_n_out}, 32'd0);
      checkOutput("req_clears_model");
`else
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 4'h0);
      checkVal("dead_stall", {25'd0, timeout_err, rst_n_out, cur_domain}, {25'd0, 1'b0, 4'b0001, 2'd0});
      checkOutput("dead_stall_model");
`endif

      $display("[TB] asynchronous reset in WAIT_ACK");
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0);
      checkVal("async_pre", {28'd0, rst_n_out}, 32'b0001);
      #1;
      reset = 1'b1;
      #1;
      checkVal("async_drop", {24'd0, rst_n_out, cur_domain, busy, all_ready}, {24'd0, 4'b0000, 2'd0, 1'b1, 1'b0});
      modelReset();
      checkOutput("async_model");
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] randomized run against model");
      doReset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            doReset();
         end
         for (int b = 0; b < N; b++) rnd[b] = ($urandom_range(0, 99) < 40);
         applyStimulus($urandom_range(0, 99) < 3, rnd);
         checkOutput("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ofs_plat_reset_sequencer.md
OFS_PLAT_RESET_SEQUENCER -- requirements
Module: ofs_plat_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4, number of sequenced reset domains (legal 2..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, minimum cycles all domains stay in reset (legal >=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, per-domain ready wait limit (legal >=2).
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock; one clock; all logic on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  synchronous soft reset request, level.
- domain_ready  in  NUM_DOMAINS  per-domain "out of reset, ready" acknowledge.
- rst_n_out  out  NUM_DOMAINS  per-domain active-low reset, registered.
- cur_domain  out  $clog2(NUM_DOMAINS)  index being released.
- busy  out  1  sequence in progress.
- all_ready  out  1  every domain released and acknowledged.
- timeout_err  out  1  sticky: a domain ack timed out.
- timeout_mask  out  NUM_DOMAINS  sticky: which domains timed out.

Function
REQ-005 SHALL implement states HOLD, RELEASE, WAIT_ACK, RUN; all outputs registered.
REQ-006 HOLD: all rst_n_out=0, hold counter increments per cycle; counter held at 0 while reset_req=1.
REQ-007 HOLD -> RELEASE when hold counter == HOLD_CYCLES-1 and reset_req=0; cur_domain=0.
REQ-008 RELEASE (exactly 1 cycle): on exit edge set rst_n_out[cur_domain]=1, clear wait counter, enter WAIT_ACK.
REQ-009 WAIT_ACK: sample domain_ready[cur_domain] each cycle; when 1, advance: cur_domain<NUM_DOMAINS-1 -> cur_domain+1, RELEASE; else RUN.
REQ-010 domain_ready bits other than cur_domain, and all bits outside WAIT_ACK, SHALL be ignored.
REQ-011 Released domains SHALL remain released (rst_n_out=1) until reset or reset_req.
REQ-012 RUN: all_ready=1, busy=0; busy=1 and all_ready=0 in every other state.
REQ-013 reset_req=1 in RELEASE, WAIT_ACK or RUN: next edge all rst_n_out=0, all_ready=0, cur_domain=0, hold counter=0, state HOLD; reset_req wins over simultaneous ack/timeout.
REQ-014 reset_req=1 SHALL clear timeout_err and timeout_mask.
REQ-015 Latency: with reset_req=0 and all ready tied 1, rst_n_out[0] rises HOLD_CYCLES+1 edges after reset deasserts, each later domain 2 edges after its predecessor, all_ready 1 edge after last rst_n_out.

Reset
REQ-016 reset=1 SHALL asynchronously force: state HOLD, counters 0, cur_domain=0, rst_n_out=all 0, busy=1, all_ready=0, timeout_err=0, timeout_mask=0.
REQ-017 Reset asserted mid-sequence SHALL drop all rst_n_out immediately (combinationally via async clear of the registers), no glitch to 1.

Configuration
REQ-018 Macro OFS_PLAT_RESET_SEQ_TIMEOUT_EN defined: wait counter counts in WAIT_ACK; at edge with counter == TIMEOUT_CYCLES-1 and no ack, set timeout_err and timeout_mask[cur_domain], advance exactly as REQ-009 (domain stays released).
REQ-019 Macro undefined: no wait counter, WAIT_ACK waits indefinitely, timeout_err and timeout_mask tied 0.

Verification
REQ-020 NUM_DOMAINS=4, HOLD_CYCLES=4, ready all 1, release reset -> rst_n_out[0..3] rise after edges 5,7,9,11; all_ready=1, busy=0 after edge 12.
REQ-021 reset_req held 1 for 20 cycles after reset release -> rst_n_out stays 0; after reset_req drops, rst_n_out[0] rises after 5th edge.
REQ-022 domain_ready[1] held 0 for 10 cycles, then 1 -> cur_domain stays 1, rst_n_out[2] stays 0 until 2 edges after ack; timeout_err=0 (TIMEOUT_CYCLES=1024).
REQ-023 Macro defined, TIMEOUT_CYCLES=8, domain_ready[0] never 1 -> 8th edge after rst_n_out[0] rises: timeout_err=1, timeout_mask=4'b0001, cur_domain=1; macro undefined -> sequence stalls at domain 0, timeout_err=0.
REQ-024 In RUN assert reset_req 1 cycle, simultaneous with domain_ready toggling -> next edge rst_n_out=4'b0000, all_ready=0, timeout_mask cleared, resequence from HOLD.
REQ-025 Assert reset asynchronously mid-WAIT_ACK (between edges) -> rst_n_out=0 before next edge, all state per REQ-016.
